// File: rtl/ssd_bcd_driver.sv
// ssd_bcd_driver
//   Converts a 13-bit binary value to four BCD digits with a sequential
//   double-dabble engine (one shift per clock), then time-multiplexes the
//   digits onto a common-anode 4-digit seven-segment display.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   num_in     binary value to display (0..8191)
//   anode      digit enables, active-low; [0] = units, [3] = thousands
//   seg        cathodes {g,f,e,d,c,b,a}, active-low
//   bcd_out    last completed conversion {thousands, hundreds, tens, units}
//   busy       high while a conversion is in progress (CONV/DONE)
//   conv_done  one-cycle pulse coincident with a bcd_out update
module ssd_bcd_driver #(
    parameter int REFRESH_BITS  = 18,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] num_in,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [15:0] bcd_out,
    output logic        busy,
    output logic        conv_done
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state_q, state_d;
    logic [12:0] last_val_q, last_val_d;
    logic [12:0] shreg_q, shreg_d;
    logic [15:0] scratch_q, scratch_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [15:0] adj;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        shreg_d    = shreg_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a value different from the last captured one starts
                // a conversion; changes seen while busy collapse to the newest.
                if (num_in != last_val_q) begin
                    shreg_d    = num_in;
                    last_val_d = num_in;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd12)
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_val_q <= '0;
            shreg_q    <= '0;
            scratch_q  <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign conv_done = done_q;
    assign bcd_out   = bcd_q;

    // ---------------- display multiplexer ----------------
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;
    logic [6:0]              seg_d;
    logic [3:0]              anode_d;
    logic [6:0]              seg_q;
    logic [3:0]              anode_q;

    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    // Always shows the committed bcd_q, so the scratch register churning
    // during a conversion never reaches the display.
    always_comb begin
        digit = bcd_q[4*sel +: 4];
        blank = 1'b0;
        case (sel)
            2'd1:    blank = (bcd_q[15:4]  == 12'd0);
            2'd2:    blank = (bcd_q[15:8]  == 8'd0);
            2'd3:    blank = (bcd_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        if (!BLANK_LEADING)
            blank = 1'b0;

        case (digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b1111111;
        endcase
        // A blanked digit keeps its anode enabled but lights no segments.
        if (blank)
            seg_d = 7'b1111111;

        anode_d = ~(4'b0001 << sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            anode_q   <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Directed bench for ssd_bcd_driver (REFRESH_BITS = 4, 4 clocks per digit).
// Instance A blanks leading zeros, instance B shows all digits.
module tb_ssd_bcd_driver;

    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] num_in;
    logic [3:0]  anode, anode_b;
    logic [6:0]  seg, seg_b;
    logic [15:0] bcd_out, bcd_out_b;
    logic        busy, busy_b, conv_done, conv_done_b;

    int nvec = 0;
    int nerr = 0;
    int tcyc;   // clocks since reset release

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;

    ssd_bcd_driver #(.REFRESH_BITS(4), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst(rst), .num_in(num_in), .anode(anode), .seg(seg),
        .bcd_out(bcd_out), .busy(busy), .conv_done(conv_done));

    ssd_bcd_driver #(.REFRESH_BITS(4), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst(rst), .num_in(num_in), .anode(anode_b), .seg(seg_b),
        .bcd_out(bcd_out_b), .busy(busy_b), .conv_done(conv_done_b));

    typedef struct {
        logic [12:0]      num;
        logic [15:0]      bcd;
        logic [3:0][6:0]  segs;   // [0] = units
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Apply num, check capture, 14-cycle latency, unchanged bcd_out while
    // busy, result, and the single-cycle done pulse.
    task automatic run_conv(input string nm, input logic [12:0] num,
                            input logic [15:0] exp, input logic [15:0] hold);
        int k;
        int lat;
        bit held;
        num_in = num;
        k = 0;
        while (!busy && k < 5) begin @(negedge clk); k++; end
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        lat  = 0;
        held = 1'b1;
        while (!conv_done && lat < 30) begin
            if (bcd_out !== hold) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({nm, " hold"}, {31'd0, held}, 32'd1);
        chk({nm, " latency"}, lat, 32'd14);
        chk({nm, " bcd"}, {16'd0, bcd_out}, {16'd0, exp});
        chk({nm, " busy_end"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({nm, " pulse"}, {31'd0, conv_done}, 32'd0);
    endtask

    // 16 cycles: anode must follow the refresh model, seg must match the
    // expected pattern of whichever digit is enabled.
    task automatic check_disp(input string nm, input logic [3:0][6:0] e, input bit b);
        int s;
        logic [3:0] an, ea;
        logic [6:0] sg;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s  = ((tcyc - 1) >> 2) & 3;
            ea = ~(4'b0001 << s);
            an = b ? anode_b : anode;
            sg = b ? seg_b : seg;
            nvec++;
            if (an !== ea || sg !== e[s]) begin
                nerr++;
                $display("FAIL %s cyc%0d: anode=%b seg=%b, expected anode=%b seg=%b",
                         nm, i, an, sg, ea, e[s]);
            end
        end
    endtask

    vec_t vt[5];
    logic [15:0] prev;
    int busy_seen;

    initial begin
        vt[0] = '{13'd1234, 16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vt[1] = '{13'd8191, 16'h8191, {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001}};
        vt[2] = '{13'd4095, 16'h4095, {7'b0011001, 7'b1000000, 7'b0010000, 7'b0010010}};
        vt[3] = '{13'd10,   16'h0010, {BL, BL, 7'b1111001, 7'b1000000}};
        vt[4] = '{13'd205,  16'h0205, {BL, 7'b0100100, 7'b1000000, 7'b0010010}};

        rst = 1'b1;
        num_in = '0;
        #23;
        chk("rst anode", {28'd0, anode}, 32'hF);
        chk("rst seg", {25'd0, seg}, 32'h7F);
        chk("rst bcd", {16'd0, bcd_out}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, conv_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // zero after reset must not start a conversion
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || conv_done) busy_seen++;
        end
        chk("idle zero busy", busy_seen, 32'd0);
        chk("idle zero bcd", {16'd0, bcd_out}, 32'd0);
        check_disp("disp zero", {BL, BL, BL, 7'b1000000}, 1'b0);

        prev = 16'h0000;
        for (int v = 0; v < 5; v++) begin
            run_conv($sformatf("vec%0d", v), vt[v].num, vt[v].bcd, prev);
            check_disp($sformatf("disp%0d", v), vt[v].segs, 1'b0);
            prev = vt[v].bcd;
        end

        // newer values arriving while busy: only the last one is converted
        num_in = 13'd100;
        @(negedge clk);
        chk("skip busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        num_in = 13'd200;
        @(negedge clk);
        num_in = 13'd300;
        begin
            int lat;
            lat = 0;
            while (!conv_done && lat < 30) begin @(negedge clk); lat++; end
            chk("skip first bcd", {16'd0, bcd_out}, 32'h0100);
        end
        run_conv("skip second", 13'd300, 16'h0300, 16'h0100);

        // reset in the middle of a conversion
        run_conv("pre42", 13'd42, 16'h0042, 16'h0300);
        num_in = 13'd999;
        @(negedge clk);
        chk("999 busy", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort bcd", {16'd0, bcd_out}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort anode", {28'd0, anode}, 32'hF);
        @(negedge clk);
        rst = 1'b0;
        run_conv("after abort", 13'd999, 16'h0999, 16'h0000);

        // single digit, with and without leading-zero blanking
        run_conv("seven", 13'd7, 16'h0007, 16'h0999);
        chk("seven b bcd", {16'd0, bcd_out_b}, 32'h0007);
        check_disp("disp7 a", {BL, BL, BL, 7'b1111000}, 1'b0);
        check_disp("disp7 b", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ssd_bcd_driver.md
Name: ssd_bcd_driver

Overview:
- Downstream consumer of the 13-bit seven-segment select value produced by the debug display-select stage.
- Converts the binary value to four BCD digits with a sequential double-dabble engine (one shift per clock).
- Time-multiplexes the four digits onto a common-anode 4-digit display (board-level, active-low anodes and cathodes).
- Also exposes the BCD result and a completion pulse for the bench.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter; the top 2 bits select the active digit (2^(REFRESH_BITS-2) clocks per digit).
- BLANK_LEADING, 1, 1 = blank leading-zero digits (the units digit is never blanked); 0 = show all four digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- num_in  input  13  binary value to display, range 0..8191.
- anode  output  4  digit enables, active-low; anode[0] = units, anode[3] = thousands.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- bcd_out  output  16  last completed conversion; {thousands, hundreds, tens, units}, one nibble each.
- busy  output  1  high while a conversion is in progress.
- conv_done  output  1  one-cycle pulse when bcd_out updates.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; last_val = 0; bcd_out = 0; busy = 0; conv_done = 0.
  - refresh counter = 0; anode = 4'b1111; seg = 7'b1111111.
  - Asserting rst mid-conversion aborts the conversion with no partial bcd_out update.
- Conversion FSM, states IDLE / CONV / DONE:
  - IDLE: if num_in != last_val, load shreg = num_in, last_val = num_in, scratch = 0, cnt = 0, go to CONV. Otherwise stay in IDLE.
  - CONV, one edge per bit: add 3 to each scratch nibble >= 5, then shift {scratch, shreg} left by 1 and increment cnt. When cnt == 12 (13th shift), go to DONE.
  - DONE: bcd_out <= scratch and conv_done = 1 for this cycle only, then go to IDLE.
  - busy = 1 in CONV and DONE.
- Latency: with the change captured at edge E0, shifts occur at E1..E13 and bcd_out/conv_done register at E14. That is 14 cycles from capture, plus at most one cycle for IDLE to see the change.
- num_in changes while busy are ignored. On return to IDLE the value is compared against last_val, so only the newest value is converted; intermediate values may be skipped. No queueing.
- Equal consecutive values never start a conversion. The value 0 after reset is not converted because bcd_out is already 0.
- Refresh and multiplexing:
  - The counter increments every clock and wraps modulo 2^REFRESH_BITS.
  - sel = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - anode and seg are registered, so each changes exactly one cycle after sel changes.
  - anode = ~(4'b0001 << sel).
- Display data:
  - The multiplexer always displays bcd_out, never the scratch register. The display does not glitch during a conversion.
- Segment encoding (active-low, {g..a}):
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000, 4: 0011001
  - 5: 0010010, 6: 0000010, 7: 1111000, 8: 0000000, 9: 0010000
  - Any nibble > 9 displays blank (1111111); this cannot occur in normal operation.
- Blanking (BLANK_LEADING = 1):
  - A digit is blanked when it and all higher digits are zero.
  - The units digit always displays.
  - A blanked digit still drives its anode low, with seg = 1111111.

Test Plan (REFRESH_BITS = 4 unless stated):
- Reset with num_in = 0, hold 40 cycles → busy never rises; bcd_out = 0. Display shows units '0' (seg 1000000 while anode = 1110); digits 1–3 show seg 1111111 while anode = 1101/1011/0111.
- num_in 0 → 1234 → conv_done pulses exactly 14 cycles after capture; bcd_out = 16'h1234. Digits cycle 4,3,2,1 on anode 1110,1101,1011,0111, each for 4 cycles.
- num_in = 8191 (max) → bcd_out = 16'h8191. num_in = 4095 → 16'h4095. num_in = 10 → 16'h0010; digits 3 and 2 blanked, tens shows '1' and units shows '0'.
- num_in = 100, then 5 cycles after capture change to 200 and then to 300 → first conv_done gives 16'h0100. Next conversion gives 16'h0300; 200 is never produced. bcd_out stays 16'h0100 throughout the second conversion.
- Assert rst at cycle 7 of a conversion of 999 (previous bcd_out = 16'h0042) → bcd_out = 0, busy = 0, anode = 1111 immediately, without waiting for a clock edge. After release with num_in still 999 → a new conversion completes with 16'h0999.
- BLANK_LEADING = 0, num_in = 7 → all four digits lit, showing 0,0,0,7.
